jesd204_versal_gt_adapter_rx_mlane: RTL
=======================================

JESD204_VERSAL_GT_ADAPTER_RX_MLANE -- requirements
Module: jesd204_versal_gt_adapter_rx_mlane

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1, number of GT lanes handled (legal 1..16).
REQ-002 SHALL have parameter SH_LOCK_CNT, default 64, consecutive valid headers to lock, and lock-monitor window length (legal 4..255).
REQ-003 SHALL have parameter SH_BAD_MAX, default 16, invalid headers within one window that drop lock (legal 1..SH_LOCK_CNT).
REQ-004 SHALL have parameter SLIP_WAIT, default 16, idle cycles after each slip pulse (legal 1..255).
REQ-005 usr_clk  input  1  sole clock; all logic on rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 rxdata  input  128*NUM_LANES  GT data per lane; bits [63:0] of each 128-bit slice used.
REQ-008 rxheader  input  6*NUM_LANES  GT header per lane; bits [1:0] of each slice used.
REQ-009 rxheadervalid  input  2*NUM_LANES  per-lane header valid; bit 0 of each slice qualifies the word.
REQ-010 rx_lane_en  input  NUM_LANES  per-lane enable.
REQ-011 rxgearboxslip  output  NUM_LANES  per-lane one-cycle gearbox slip pulse.
REQ-012 rx_data  output  64*NUM_LANES  aligned, bit-reversed data per lane.
REQ-013 rx_header  output  2*NUM_LANES  sync header per lane.
REQ-014 rx_block_sync  output  NUM_LANES  per-lane block lock.
REQ-015 rx_all_sync  output  1  all enabled lanes locked.

Function
REQ-016 Per lane, word valid (wv) = rxheadervalid[2*i]; when wv=1, rx_data[64*i+63-k] <= rxdata[128*i+k] for k=0..63, and rx_header[2*i+1:2*i] <= {rxheader[6*i], rxheader[6*i+1]}; registered, 1-cycle latency.
REQ-017 When wv=0, rx_data and rx_header of that lane hold their previous values.
REQ-018 Header valid iff received 2-bit header (after swap) is 2'b01 or 2'b10; 2'b00 and 2'b11 invalid.
REQ-019 Each lane SHALL run an independent FSM with states HUNT, SLIP, WAIT, LOCK.
REQ-020 HUNT: on wv with valid header, good counter +1; on reaching SH_LOCK_CNT -> LOCK with counters cleared; on wv with invalid header -> SLIP.
REQ-021 SLIP: rxgearboxslip high for exactly one cycle, then -> WAIT unconditionally.
REQ-022 WAIT: count SLIP_WAIT usr_clk cycles regardless of wv, then -> HUNT with good counter cleared; no header evaluation in WAIT.
REQ-023 LOCK: each wv increments window counter; invalid header increments bad counter; bad counter reaching SH_BAD_MAX -> SLIP; window counter reaching SH_LOCK_CNT with bad < SH_BAD_MAX clears both counters, stays LOCK.
REQ-024 Simultaneous window end and SH_BAD_MAX-th bad header: SLIP wins.
REQ-025 wv=0 cycles SHALL not change good, window or bad counters in HUNT or LOCK.
REQ-026 rx_block_sync[i] = 1 exactly while lane i FSM is in LOCK (registered state decode).
REQ-027 rxgearboxslip SHALL never be high on two consecutive cycles for a lane; minimum spacing SLIP_WAIT+2 cycles.
REQ-028 rx_lane_en[i]=0: lane FSM forced to HUNT, counters cleared, rxgearboxslip[i]=0, rx_block_sync[i]=0; data path still updates.
REQ-029 Deasserting rx_lane_en mid-SLIP/WAIT/LOCK SHALL take effect next cycle; no further slip pulse issued.
REQ-030 rx_all_sync = AND over enabled lanes of rx_block_sync, registered; 0 when no lane enabled.
REQ-031 Counters SHALL be sized to hold their max parameter value without wrap; no counter wraps.

Reset
REQ-032 resetn=0 at a rising edge: all FSMs -> HUNT, all counters 0, rx_data=0, rx_header=0, rxgearboxslip=0, rx_block_sync=0, rx_all_sync=0.
REQ-033 Reset mid-WAIT or mid-LOCK SHALL abort immediately; no residual slip pulse after release.
REQ-034 First header evaluation SHALL occur on the first cycle after resetn returns high.

Verification
REQ-035 NUM_LANES=1, defaults: 64 consecutive wv words with header 2'b01 -> rx_block_sync rises one cycle after 64th word; rxgearboxslip never pulses.
REQ-036 Header 2'b11 in HUNT -> single 1-cycle rxgearboxslip, then 16 cycles ignored, then hunting restarts with good counter 0.
REQ-037 Locked lane, 15 bad headers in a 64-word window -> lock held; 16 bad headers in one window -> rx_block_sync falls and one slip pulse issued.
REQ-038 rxdata[63:0]=64'h0000_0000_0000_0001, rxheader[1:0]=2'b10, wv=1 -> next cycle rx_data=64'h8000_0000_0000_0000, rx_header=2'b01.
REQ-039 NUM_LANES=4, rx_lane_en=4'b1011, lanes 0,1,3 locked, lane 2 idle -> rx_all_sync=1; lane 1 loses lock -> rx_all_sync=0 next cycle; rx_lane_en=0 -> rx_all_sync=0.
REQ-040 resetn low for one cycle while locked with wv toggling -> all outputs 0 next cycle; relock needs full 64 valid headers.

Source files
------------

// File: rtl/jesd204_versal_gt_adapter_rx_mlane.sv
// Multi-lane RX adapter for Versal GT 64b/66b: bit-reverses data, swaps the sync
// header and runs an independent header-lock FSM per lane that drives the gearbox slip.
module jesd204_versal_gt_adapter_rx_mlane #(
  parameter int NUM_LANES   = 1,
  parameter int SH_LOCK_CNT = 64,
  parameter int SH_BAD_MAX  = 16,
  parameter int SLIP_WAIT   = 16
) (
  input  logic                     usr_clk,
  input  logic                     resetn,
  input  logic [128*NUM_LANES-1:0] rxdata,
  input  logic [6*NUM_LANES-1:0]   rxheader,
  input  logic [2*NUM_LANES-1:0]   rxheadervalid,
  input  logic [NUM_LANES-1:0]     rx_lane_en,
  output logic [NUM_LANES-1:0]     rxgearboxslip,
  output logic [64*NUM_LANES-1:0]  rx_data,
  output logic [2*NUM_LANES-1:0]   rx_header,
  output logic [NUM_LANES-1:0]     rx_block_sync,
  output logic                     rx_all_sync
);

  localparam int CW = $clog2(SH_LOCK_CNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SLIP = 2'd1,
    WAIT = 2'd2,
    LOCK = 2'd3
  } state_t;

  logic all_sync_q, all_sync_d;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic          wv;
    logic [1:0]    hdr;
    logic          hdr_ok;
    logic [63:0]   data_rev;
    logic          unused_lane;

    state_t        state_q, state_d;
    logic [CW-1:0] good_q, good_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] bad_q, bad_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          slip_q, sync_q;
    logic [63:0]   data_q, data_d;
    logic [1:0]    hdr_q, hdr_d;

    assign wv          = rxheadervalid[2*gi];
    assign hdr         = {rxheader[6*gi], rxheader[6*gi+1]};
    assign hdr_ok      = hdr[0] ^ hdr[1];
    assign unused_lane = ^{rxdata[128*gi+64 +: 64], rxheader[6*gi+2 +: 4], rxheadervalid[2*gi+1]};

    always_comb begin
      data_rev = '0;
      for (int k = 0; k < 64; k++) data_rev[63-k] = rxdata[128*gi+k];
      data_d = wv ? data_rev : data_q;
      hdr_d  = wv ? hdr : hdr_q;
    end

    always_comb begin
      state_d = state_q;
      good_d  = good_q;
      win_d   = win_q;
      bad_d   = bad_q;
      wait_d  = wait_q;
      if (!rx_lane_en[gi]) begin
        state_d = HUNT;
        good_d  = '0;
        win_d   = '0;
        bad_d   = '0;
        wait_d  = '0;
      end else begin
        case (state_q)
          HUNT: if (wv) begin
            if (!hdr_ok) begin
              state_d = SLIP;
              good_d  = '0;
            end else if (good_q + CW'(1) == CW'(SH_LOCK_CNT)) begin
              state_d = LOCK;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + CW'(1);
            end
          end
          SLIP: begin
            state_d = WAIT;
            wait_d  = '0;
          end
          WAIT: begin
            if (wait_q + WW'(1) == WW'(SLIP_WAIT)) begin
              state_d = HUNT;
              good_d  = '0;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
          LOCK: if (wv) begin
            // Losing lock takes priority over a coincident window roll-over.
            if (!hdr_ok && (bad_q + CW'(1) == CW'(SH_BAD_MAX))) begin
              state_d = SLIP;
              win_d   = '0;
              bad_d   = '0;
            end else if (win_q + CW'(1) == CW'(SH_LOCK_CNT)) begin
              win_d = '0;
              bad_d = '0;
            end else begin
              win_d = win_q + CW'(1);
              bad_d = bad_q + (hdr_ok ? CW'(0) : CW'(1));
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end

    always_ff @(posedge usr_clk) begin
      if (!resetn) begin
        state_q <= HUNT;
        good_q  <= '0;
        win_q   <= '0;
        bad_q   <= '0;
        wait_q  <= '0;
        slip_q  <= 1'b0;
        sync_q  <= 1'b0;
        data_q  <= '0;
        hdr_q   <= '0;
      end else begin
        state_q <= state_d;
        good_q  <= good_d;
        win_q   <= win_d;
        bad_q   <= bad_d;
        wait_q  <= wait_d;
        slip_q  <= (state_d == SLIP);
        sync_q  <= (state_d == LOCK);
        data_q  <= data_d;
        hdr_q   <= hdr_d;
      end
    end

    assign rxgearboxslip[gi]     = slip_q;
    assign rx_block_sync[gi]     = sync_q;
    assign rx_data[64*gi +: 64]  = data_q;
    assign rx_header[2*gi +: 2]  = hdr_q;
  end

  always_comb begin
    all_sync_d = |rx_lane_en;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rx_lane_en[i] && !rx_block_sync[i]) all_sync_d = 1'b0;
    end
  end

  always_ff @(posedge usr_clk) begin
    if (!resetn) all_sync_q <= 1'b0;
    else         all_sync_q <= all_sync_d;
  end

  assign rx_all_sync = all_sync_q;

endmodule
